// File: rtl/aes_dec_loader.sv
// Word-serial loader for the AES-128 decipher: assembles key/ciphertext, sequences kld/ld, captures plaintext.
// Latency: dec_kld one cycle after start and dec_ld KEY_WAIT+1 cycles later; dec_ld one cycle after start when the key is unchanged.
// Backpressure: writes and start are ignored while busy; the result holds until the next accepted start.
`timescale 1ns/1ps
module aes_dec_loader #(
    parameter int KEY_WAIT = 12,
    parameter int TIMEOUT  = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [1:0]   wr_idx,
    input  logic [31:0]  wr_data,
    input  logic         start,
    output logic         busy,
    output logic         rdy,
    output logic         err,
    input  logic [1:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic         dec_kld,
    output logic         dec_ld,
    output logic [127:0] dec_key,
    output logic [127:0] dec_text_in,
    input  logic         dec_done,
    input  logic [127:0] dec_text_out
);

    localparam int CNT_MAX = (KEY_WAIT > TIMEOUT) ? KEY_WAIT : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLD   = 3'd1,
        KWAIT = 3'd2,
        LD    = 3'd3,
        RUN   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [127:0]   key_reg;
    logic [127:0]   text_reg;
    logic [127:0]   result_reg;
    logic [CW-1:0]  cnt;
    logic           key_dirty;
    logic           rdy_reg;
    logic           err_reg;

    // Word 0 is the most significant slice, so the bit offset is (3 - idx) * 32.
    logic [6:0]     wr_lsb;
    logic [6:0]     rd_lsb;
    logic           wr_ok;
    logic           wait_done;
    logic           run_timeout;

    assign wr_lsb      = {~wr_idx, 5'b0};
    assign rd_lsb      = {~rd_idx, 5'b0};
    assign wr_ok       = wr_en && (state == IDLE);
    assign wait_done   = (cnt == '0);
    assign run_timeout = (cnt == CW'(TIMEOUT - 1));

    assign busy        = (state != IDLE);
    assign rdy         = rdy_reg;
    assign err         = err_reg;
    assign dec_kld     = (state == KLD);
    assign dec_ld      = (state == LD);
    assign dec_key     = key_reg;
    assign dec_text_in = text_reg;
    assign rd_data     = result_reg[rd_lsb +: 32];

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a key write in the start cycle forces the reload path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (key_dirty || (wr_en && wr_sel)) ? KLD : LD;
                end
            end
            KLD:   state_next = KWAIT;
            KWAIT: begin
                if (wait_done) begin
                    state_next = LD;
                end
            end
            LD:    state_next = RUN;
            RUN: begin
                if (dec_done || run_timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand registers, counters, status flags and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_reg    <= '0;
            text_reg   <= '0;
            result_reg <= '0;
            cnt        <= '0;
            key_dirty  <= 1'b1;
            rdy_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (wr_ok) begin
                if (wr_sel) begin
                    key_reg[wr_lsb +: 32] <= wr_data;
                    key_dirty             <= 1'b1;
                end else begin
                    text_reg[wr_lsb +: 32] <= wr_data;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        rdy_reg <= 1'b0;
                        err_reg <= 1'b0;
                    end
                end
                KLD: begin
                    key_dirty <= 1'b0;
                    cnt       <= CW'(KEY_WAIT - 1);
                end
                KWAIT: begin
                    if (!wait_done) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                LD: begin
                    cnt <= '0;
                end
                RUN: begin
                    if (dec_done) begin
                        result_reg <= dec_text_out;
                        rdy_reg    <= 1'b1;
                    end else if (run_timeout) begin
                        // The decipher may be in an unknown state, so reload the key next time.
                        err_reg   <= 1'b1;
                        key_dirty <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_loader.sv
`timescale 1ns/1ps
module tb_aes_dec_loader;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic         wr_sel;
    logic [1:0]   wr_idx;
    logic [31:0]  wr_data;
    logic         start;
    logic         busy;
    logic         rdy;
    logic         err;
    logic [1:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         dec_kld;
    logic         dec_ld;
    logic [127:0] dec_key;
    logic [127:0] dec_text_in;
    logic         dec_done;
    logic [127:0] dec_text_out;

    aes_dec_loader dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .rdy          (rdy),
        .err          (err),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .dec_kld      (dec_kld),
        .dec_ld       (dec_ld),
        .dec_key      (dec_key),
        .dec_text_in  (dec_text_in),
        .dec_done     (dec_done),
        .dec_text_out (dec_text_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cycle index and pulse history, sampled at the edge that ends each cycle.
    int           cyc    = 0;
    int           kld_n  = 0;
    int           ld_n   = 0;
    int           kld_at = -1;
    int           ld_at  = -1;
    logic [127:0] kld_key = '0;
    int           sc     = 0;

    always @(posedge clk) begin
        if (dec_kld) begin
            kld_n   <= kld_n + 1;
            kld_at  <= cyc;
            kld_key <= dec_key;
        end
        if (dec_ld) begin
            ld_n  <= ld_n + 1;
            ld_at <= cyc;
        end
        cyc <= cyc + 1;
    end

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] PT3  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT4  = 128'h13579bdf2468ace0fedcba9876543210;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic sel, input logic [1:0] idx, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        sc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ld(input int n);
        for (int i = 0; i < 60 && ld_n < n; i++) step();
        chk("ld_seen", ld_n, n);
    endtask

    task automatic wait_kld(input int n);
        for (int i = 0; i < 60 && kld_n < n; i++) step();
        chk("kld_seen", kld_n, n);
    endtask

    task automatic done_pulse(input logic [127:0] pt);
        dec_text_out = pt;
        dec_done = 1'b1;
        step();
        dec_done = 1'b0;
        dec_text_out = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        rd_idx = idx;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rdy"}, rdy, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_kld"}, dec_kld, 1'b0);
        chk({tag, "_ld"}, dec_ld, 1'b0);
        chk({tag, "_key"}, dec_key, 128'h0);
        chk({tag, "_text"}, dec_text_in, 128'h0);
        rd_chk({tag, "_rd"}, 2'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = '0;
        start = 1'b0; rd_idx = 2'd0; dec_done = 1'b0; dec_text_out = '0;
        step(); step();
        chk_idle_zero("reset");
        rst = 1'b1;
        step();

        // Full decrypt with the FIPS-197 vector; fresh key takes the reload path.
        wr(1'b1, 2'd0, 32'h00010203); wr(1'b1, 2'd1, 32'h04050607);
        wr(1'b1, 2'd2, 32'h08090a0b); wr(1'b1, 2'd3, 32'h0c0d0e0f);
        wr(1'b0, 2'd0, 32'h69c4e0d8); wr(1'b0, 2'd1, 32'h6a7b0430);
        wr(1'b0, 2'd2, 32'hd8cdb780); wr(1'b0, 2'd3, 32'h70b4c55a);
        chk("t1_key", dec_key, KEY1);
        chk("t1_text", dec_text_in, CT1);
        go();
        wait_ld(1);
        chk("t1_kld_n", kld_n, 1);
        chk("t1_kld_lat", kld_at, sc + 1);
        chk("t1_ld_gap", ld_at - kld_at, 13);
        chk("t1_busy", busy, 1'b1);
        chk("t1_rdy_low", rdy, 1'b0);
        done_pulse(PT1);
        chk("t1_rdy", rdy, 1'b1);
        chk("t1_busy_low", busy, 1'b0);
        chk("t1_err", err, 1'b0);
        rd_chk("t1_rd0", 2'd0, 32'h00112233);
        rd_chk("t1_rd1", 2'd1, 32'h44556677);
        rd_chk("t1_rd2", 2'd2, 32'h8899aabb);
        rd_chk("t1_rd3", 2'd3, 32'hccddeeff);

        // Key unchanged: ciphertext-only update skips the key schedule.
        wr(1'b0, 2'd3, 32'h11223344);
        go();
        wait_ld(2);
        chk("t2_kld_n", kld_n, 1);
        chk("t2_ld_lat", ld_at, sc + 1);
        chk("t2_text", dec_text_in, 128'h69c4e0d86a7b0430d8cdb78011223344);
        done_pulse(PT2);
        chk("t2_rdy", rdy, 1'b1);
        rd_chk("t2_rd0", 2'd0, 32'hdeadbeef);
        rd_chk("t2_rd3", 2'd3, 32'hcafef00d);

        // dec_done while idle must not disturb the held result.
        dec_text_out = 128'h0; dec_done = 1'b1;
        step();
        dec_done = 1'b0;
        step();
        rd_chk("idle_done_rd0", 2'd0, 32'hdeadbeef);
        chk("idle_done_rdy", rdy, 1'b1);
        chk("idle_done_busy", busy, 1'b0);

        // Key write and start while running are both ignored.
        go();
        wait_ld(3);
        wr_en = 1'b1; wr_sel = 1'b1; wr_idx = 2'd0; wr_data = 32'hffffffff; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("t5_key", dec_key, KEY1);
        chk("t5_busy", busy, 1'b1);
        done_pulse(PT3);
        chk("t5_rdy", rdy, 1'b1);
        rd_chk("t5_rd1", 2'd1, 32'h0b0a0908);
        repeat (20) step();
        chk("t5_no_second_op", ld_n, 3);
        chk("t5_idle", busy, 1'b0);
        go();
        wait_ld(4);
        chk("t5_clean_kld_n", kld_n, 1);
        chk("t5_clean_ld_lat", ld_at, sc + 1);

        // Timeout: no dec_done, so the operation aborts after 31 RUN cycles.
        for (int i = 0; i < 60 && busy; i++) step();
        chk("t3_to_cycle", cyc, ld_at + 32);
        chk("t3_busy", busy, 1'b0);
        chk("t3_err", err, 1'b1);
        chk("t3_rdy", rdy, 1'b0);
        go();
        wait_kld(2);
        chk("t3_reload_lat", kld_at, sc + 1);
        chk("t3_err_clr", err, 1'b0);
        chk("t3_busy_kw", busy, 1'b1);

        // Synchronous reset while waiting for the key schedule.
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_idle_zero("t4");
        repeat (20) step();
        chk("t4_no_ld", ld_n, 4);
        go();
        wait_kld(3);
        chk("t4_kld_lat", kld_at, sc + 1);
        wait_ld(5);
        chk("t4_ld_gap", ld_at - kld_at, 13);
        done_pulse(PT4);
        chk("t4_rdy", rdy, 1'b1);
        rd_chk("t4_rd2", 2'd2, 32'hfedcba98);

        // Key write in the same cycle as start forces the reload path with the new word.
        wr_en = 1'b1; wr_sel = 1'b1; wr_idx = 2'd3; wr_data = 32'ha5a5a5a5; start = 1'b1;
        sc = cyc;
        step();
        wr_en = 1'b0; start = 1'b0;
        wait_kld(4);
        chk("t6_kld_lat", kld_at, sc + 1);
        chk("t6_kld_key", kld_key, 128'h000000000000000000000000a5a5a5a5);
        wait_ld(6);
        chk("t6_ld_gap", ld_at - kld_at, 13);
        done_pulse(PT1);
        chk("t6_rdy", rdy, 1'b1);
        rd_chk("t6_rd3", 2'd3, 32'hccddeeff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_dec_loader.md
Name: aes_dec_loader

Overview:
- Word-serial front end for the AES-128 decipher core: the RISC-V core writes 32-bit key and ciphertext words; result words are read back.
- Assembles 128-bit key/ciphertext registers and sequences the decipher's kld/ld handshake, skipping key-schedule reload when the key is unchanged.
- Waits for done with a timeout, captures text_out and presents it as four readable words.
- Sits directly upstream of, and consumes the output of, the decipher core in the crypto unit.

Parameters:
KEY_WAIT, 12, cycles waited after the dec_kld pulse before dec_ld may be issued (decipher key-schedule fill time).
TIMEOUT, 31, cycles in RUN without dec_done before aborting with err.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
wr_en  in  1  word write strobe
wr_sel  in  1  0 = ciphertext register, 1 = key register
wr_idx  in  2  word index; 0 = bits [127:96] … 3 = bits [31:0]
wr_data  in  32  write data
start  in  1  one-cycle request to decrypt current ciphertext
busy  out  1  operation in progress
rdy  out  1  result valid
err  out  1  last operation timed out
rd_idx  in  2  result word select, same ordering as wr_idx
rd_data  out  32  result word, combinational from result register
dec_kld  out  1  key load pulse to decipher
dec_ld  out  1  text load pulse to decipher
dec_key  out  128  key register
dec_text_in  out  128  ciphertext register
dec_done  in  1  decipher done pulse
dec_text_out  in  128  decipher plaintext, valid while dec_done=1

Behaviour:
- Reset (rst=0 at posedge) values:
  - key, ciphertext and result registers = 0.
  - state = IDLE.
  - busy = rdy = err = dec_kld = dec_ld = 0.
  - key_dirty = 1.
  - Reset mid-operation aborts immediately; no result captured.
- Writes:
  - Accepted only in IDLE; the addressed 32-bit slice updates at the edge.
  - Any key write sets key_dirty.
  - Writes while busy are ignored and leave key_dirty unchanged.
- FSM states: IDLE, KLD, KWAIT, LD, RUN.
  - IDLE, start=1: clear rdy and err, set busy; go to KLD if key_dirty, else LD.
  - KLD: dec_kld=1 for exactly this cycle; clear key_dirty; load wait counter; go to KWAIT.
  - KWAIT: stay KEY_WAIT cycles, then go to LD.
  - LD: dec_ld=1 for exactly this cycle; clear timeout counter; go to RUN.
  - RUN, dec_done=1: result <= dec_text_out; rdy=1, busy=0; go to IDLE.
  - RUN, counter reaches TIMEOUT with no dec_done: err=1, busy=0, rdy stays 0; set key_dirty (forces reload); go to IDLE.
- start while busy is ignored; start in IDLE is level-sampled once.
- Simultaneous wr_en and start in IDLE: the write is applied and included in the operation.
  - This holds because dec_kld/dec_ld occur no earlier than the next cycle.
  - A key write in the same cycle forces the KLD path.
- dec_done outside RUN is ignored.
- Latency, start sampled at edge T0:
  - Reload path: dec_kld in cycle T0+1; dec_ld in cycle T0+2+KEY_WAIT.
  - No-reload path: dec_ld in cycle T0+1.
- rdy/result stay valid until the next accepted start or reset.
- rd_data always reflects result[rd_idx].
- dec_key and dec_text_in are driven directly from their registers and are stable during busy.

Test Plan:
1. Full decrypt, FIPS-197 vector:
   - Stimulus: write key 000102030405060708090a0b0c0d0e0f and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, then start.
   - Required: one dec_kld pulse; dec_ld exactly 13 cycles later; rdy=1.
   - Required read-back: rd_idx 0..3 returns 00112233, 44556677, 8899aabb, ccddeeff.
2. Key unchanged:
   - Stimulus: write new ciphertext only, then start.
   - Required: no dec_kld; dec_ld in the cycle after start; result matches the model.
3. Timeout:
   - Stimulus: stub decipher never asserts dec_done.
   - Required: after 31 RUN cycles, busy=0, err=1, rdy=0.
   - Required: the next start takes the KLD path.
4. Reset during KWAIT:
   - Stimulus: rst=0 for one cycle.
   - Required: state IDLE, all outputs 0, key_dirty=1; the subsequent start pulses dec_kld.
5. Writes and start while busy:
   - Stimulus: during RUN, write key word 0 = ffffffff and assert start.
   - Required: dec_key unchanged; no second operation; key_dirty stays 0.
6. Same-cycle write and start in IDLE:
   - Stimulus: wr_sel=1, wr_idx=3, start=1 in the same cycle.
   - Required: KLD path taken; dec_key[31:0] already equals the new word at the dec_kld pulse.
